// File: rtl/wbuf_read_sched.sv
// Weight-buffer read sequencer: walks rows x passes of one tile descriptor,
// honours stall, holds the fc mode select and waits out the chain drain.
module wbuf_read_sched #(
   parameter int BUF_ADDR_WIDTH = 9,
   parameter int CNT_W          = 12,
   parameter int CONV_DRAIN     = 4,
   parameter int FC_DRAIN       = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [BUF_ADDR_WIDTH-1:0] cfg_base_addr,
   input  logic [BUF_ADDR_WIDTH-1:0] cfg_row_stride,
   input  logic [BUF_ADDR_WIDTH-1:0] cfg_pass_stride,
   input  logic [CNT_W-1:0]          cfg_num_rows,
   input  logic [CNT_W-1:0]          cfg_num_passes,
   input  logic                      cfg_fc,
   input  logic                      stall,
   output logic                      buf_read_req,
   output logic [BUF_ADDR_WIDTH-1:0] buf_read_addr,
   output logic                      fc,
   output logic                      pass_last,
   output logic                      busy,
   output logic                      done
);
   localparam int DRAIN_MAX = (FC_DRAIN > CONV_DRAIN) ? FC_DRAIN : CONV_DRAIN;
   localparam int DRAIN_W   = $clog2(DRAIN_MAX + 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t                    state_reg, state_next;
   logic [CNT_W-1:0]          row_reg, row_next;
   logic [CNT_W-1:0]          pass_reg, pass_next;
   logic [CNT_W-1:0]          num_rows_reg, num_rows_next;
   logic [CNT_W-1:0]          num_passes_reg, num_passes_next;
   logic [BUF_ADDR_WIDTH-1:0] row_stride_reg, row_stride_next;
   logic [BUF_ADDR_WIDTH-1:0] pass_stride_reg, pass_stride_next;
   logic [BUF_ADDR_WIDTH-1:0] pass_base_reg, pass_base_next;
   logic [BUF_ADDR_WIDTH-1:0] addr_acc_reg, addr_acc_next;
   logic [DRAIN_W-1:0]        drain_reg, drain_next;
   logic                      req_reg, req_next;
   logic [BUF_ADDR_WIDTH-1:0] addr_reg, addr_next;
   logic                      fc_reg, fc_next;
   logic                      pass_last_reg, pass_last_next;
   logic                      busy_reg, busy_next;
   logic                      done_reg, done_next;
   logic                      row_last, pass_final;

   assign row_last   = (row_reg == (num_rows_reg - CNT_W'(1)));
   assign pass_final = (pass_reg == (num_passes_reg - CNT_W'(1)));

   always_comb begin
      state_next       = state_reg;
      row_next         = row_reg;
      pass_next        = pass_reg;
      num_rows_next    = num_rows_reg;
      num_passes_next  = num_passes_reg;
      row_stride_next  = row_stride_reg;
      pass_stride_next = pass_stride_reg;
      pass_base_next   = pass_base_reg;
      addr_acc_next    = addr_acc_reg;
      drain_next       = drain_reg;
      req_next         = 1'b0;
      addr_next        = addr_reg;
      fc_next          = fc_reg;
      pass_last_next   = 1'b0;
      busy_next        = 1'b0;
      done_next        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               num_rows_next    = cfg_num_rows;
               num_passes_next  = cfg_num_passes;
               row_stride_next  = cfg_row_stride;
               pass_stride_next = cfg_pass_stride;
               pass_base_next   = cfg_base_addr;
               addr_acc_next    = cfg_base_addr;
               fc_next          = cfg_fc;
               row_next         = '0;
               pass_next        = '0;
               if (cfg_num_rows != '0 && cfg_num_passes != '0) begin
                  state_next = READ;
                  busy_next  = 1'b1;
               end else begin
                  state_next = DONE;
                  done_next  = 1'b1;
               end
            end
         end
         READ: begin
            busy_next = 1'b1;
            if (!stall) begin
               req_next       = 1'b1;
               addr_next      = addr_acc_reg;
               pass_last_next = row_last;
               // Address of the next read is kept ready in addr_acc; at a pass
               // boundary it restarts from the advanced pass base.
               if (row_last) begin
                  row_next       = '0;
                  pass_next      = pass_reg + CNT_W'(1);
                  pass_base_next = pass_base_reg + pass_stride_reg;
                  addr_acc_next  = pass_base_reg + pass_stride_reg;
                  if (pass_final) begin
                     state_next = DRAIN;
                     drain_next = fc_reg ? DRAIN_W'(FC_DRAIN) : DRAIN_W'(CONV_DRAIN);
                  end
               end else begin
                  row_next      = row_reg + CNT_W'(1);
                  addr_acc_next = addr_acc_reg + row_stride_reg;
               end
            end
         end
         DRAIN: begin
            if (drain_reg == DRAIN_W'(1)) begin
               state_next = DONE;
               done_next  = 1'b1;
            end else begin
               drain_next = drain_reg - DRAIN_W'(1);
               busy_next  = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= IDLE;
         row_reg         <= '0;
         pass_reg        <= '0;
         num_rows_reg    <= '0;
         num_passes_reg  <= '0;
         row_stride_reg  <= '0;
         pass_stride_reg <= '0;
         pass_base_reg   <= '0;
         addr_acc_reg    <= '0;
         drain_reg       <= '0;
         req_reg         <= 1'b0;
         addr_reg        <= '0;
         fc_reg          <= 1'b0;
         pass_last_reg   <= 1'b0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
      end else begin
         state_reg       <= state_next;
         row_reg         <= row_next;
         pass_reg        <= pass_next;
         num_rows_reg    <= num_rows_next;
         num_passes_reg  <= num_passes_next;
         row_stride_reg  <= row_stride_next;
         pass_stride_reg <= pass_stride_next;
         pass_base_reg   <= pass_base_next;
         addr_acc_reg    <= addr_acc_next;
         drain_reg       <= drain_next;
         req_reg         <= req_next;
         addr_reg        <= addr_next;
         fc_reg          <= fc_next;
         pass_last_reg   <= pass_last_next;
         busy_reg        <= busy_next;
         done_reg        <= done_next;
      end
   end

   assign buf_read_req  = req_reg;
   assign buf_read_addr = addr_reg;
   assign fc            = fc_reg;
   assign pass_last     = pass_last_reg;
   assign busy          = busy_reg;
   assign done          = done_reg;
endmodule
